// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY receive-path definitions: symbol constants and the
// serial aligner state encoding.
package pcie_phy_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COM_SYM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } align_state_e;

endpackage

// File: rtl/serial_to_parallel_aligner_if.sv
// Serial input and byte output bundle between the aligner and its neighbours
// (bit source upstream, 1x2 byte demux downstream).
interface serial_to_parallel_aligner_if;
  import pcie_phy_pkg::*;

  logic              serial_in;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              active;

  modport master (output serial_in, input data_out, valid_out, active);
  modport slave  (input serial_in, output data_out, valid_out, active);

endinterface

// File: rtl/shift_reg_8b.sv
// 8-bit serial-in/parallel-out shifter; window is the byte that will be held
// after the current edge, i.e. the last seven bits plus the incoming one.
module shift_reg_8b
  import pcie_phy_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              din,
  output logic [BYTE_W-1:0] window
);

  // The oldest bit of the full register never reaches the window, so only
  // the seven younger bits are kept.
  logic [BYTE_W-2:0] hist_q;

  assign window = {hist_q, din};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) hist_q <= '0;
    else        hist_q <= window[BYTE_W-2:0];
  end

endmodule

// File: rtl/serial_to_parallel_aligner.sv
// Receive deserializer: hunts for COM at bit granularity, locks after BC_COUNT
// aligned COMs, then strobes each non-COM byte to the byte demux.
module serial_to_parallel_aligner
  import pcie_phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_SYM  = COM_SYM_DEFAULT,
  parameter int unsigned       BC_COUNT = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  serial_to_parallel_aligner_if.slave  bus
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  logic [BYTE_W-1:0] window;
  align_state_e      state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        com_cnt_q, com_cnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;

  shift_reg_8b u_shift (
    .clk    (clk),
    .clr_n  (reset_L),
    .din    (bus.serial_in),
    .window (window)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;

    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (window == COM_SYM) begin
          com_cnt_d = 4'd1;
          if (BC_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d  = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (bit_cnt_q == 3'd7) begin
          if (window == COM_SYM) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if ((com_cnt_q + 4'd1) == BC_TARGET) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // Broken run: hunt restarts on the following edge.
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end

      ACTIVE: begin
        if (bit_cnt_q == 3'd7) begin
          data_d  = window;
          valid_d = (window != COM_SYM);
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule

// File: doc/serial_to_parallel_aligner.md
Name: serial_to_parallel_aligner

Overview:
- Receive-side deserializer that sits directly upstream of the 1x2 byte demux (byte un-striping stage) in the PCIe physical-layer path.
- Shifts in a serial bit stream, MSB first, and finds byte alignment by hunting for the COM symbol.
- Declares the link active after a run of consecutive aligned COMs.
- In the active state, presents each non-COM byte on an 8-bit bus with a one-cycle valid strobe. These outputs drive the demux's In0/validIn.

Parameters:
- COM_SYM, 8'hBC, alignment/idle symbol.
- BC_COUNT, 4, consecutive aligned COM symbols, including the first found, required to enter ACTIVE. Legal range 1..15.

Ports:
- clk  input  1  single bit-rate clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit, sampled every rising clk edge, MSB of each byte first.
- data_out  output  8  last completed byte (feeds demux In0).
- valid_out  output  1  one-cycle strobe: data_out holds a new non-COM byte (feeds demux validIn).
- active  output  1  link aligned and active.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_L).
- Reset (reset_L=0, asynchronous):
  - State=SEARCH, shift_reg=0, bit_cnt=0, com_cnt=0.
  - data_out=8'h00, valid_out=0, active=0.
- Shifting:
  - Every edge: shift_reg <= {shift_reg[6:0], serial_in}.
  - Define window = {shift_reg[6:0], serial_in}, the combinational next value.
- FSM states: SEARCH, ALIGN, ACTIVE.
- SEARCH:
  - Compares window to COM_SYM every cycle (bit-granular hunt).
  - On match: bit_cnt<=0, com_cnt<=1.
  - Next state is ALIGN. If BC_COUNT==1, next state is ACTIVE with active<=1.
- Byte boundary (ALIGN and ACTIVE):
  - bit_cnt increments each edge, 3-bit, wrapping 7->0.
  - The edge where bit_cnt==7 is a byte-complete edge; the byte is window.
- ALIGN, at byte-complete:
  - byte==COM_SYM: com_cnt<=com_cnt+1. If com_cnt+1==BC_COUNT, go to ACTIVE and set active<=1 on that edge.
  - byte!=COM_SYM: go to SEARCH, com_cnt<=0. The hunt resumes on the next edge; no COM overlap check on this edge.
  - ALIGN never asserts valid_out and never updates data_out.
- ACTIVE, at byte-complete:
  - data_out<=byte, including COM bytes.
  - valid_out<=(byte!=COM_SYM).
- ACTIVE, all other edges: valid_out<=0 and data_out holds.
- Latency: valid_out and data_out are valid in the cycle immediately after the edge that sampled the byte's 8th bit. The strobe is exactly one clk wide, at most once per 8 cycles.
- ACTIVE is sticky. No loss-of-alignment detection; exit only via reset_L.
- Mid-operation reset: all outputs return to reset values immediately, without waiting for a clock edge. The first edge after reset_L rises is in SEARCH.
- Global invariants:
  - active=0 implies valid_out=0.
  - active never falls except by reset.
  - Never more than one valid_out per 8 cycles.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - COM_SYM default (8'hBC);
  - FSM state encoding (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2);
  - byte width constant 8.
- A single optional sub-module, shift_reg_8b (8-bit serial-in/parallel-out shift register with async active-low clear), supplies shift_reg/window.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Clean lock, default params:
  - Stimulus: BC, BC, BC, BC, 5A, 3C serially, MSB first.
  - Response: active rises one cycle after the 32nd bit's edge.
  - Response: valid_out=1 with data_out=8'h5A one cycle after bit 40.
  - Response: valid_out=1 with data_out=8'h3C one cycle after bit 48; valid_out=0 elsewhere.
- Misaligned start:
  - Stimulus: 3 bits 101, then BC x4, then A7.
  - Response: lock as above, offset by 3 cycles; data_out=8'hA7 strobed once.
- Broken COM run:
  - Stimulus: BC, BC, 00, then 5A.
  - Response: return to SEARCH at the 00 byte; active stays 0; no valid_out.
  - Stimulus continued: then BC x4, 11.
  - Response: active=1; 8'h11 strobed.
- Idle in ACTIVE:
  - Stimulus: after lock, BC, BC, 7E.
  - Response: data_out updates to BC with valid_out=0 twice; then data_out=8'h7E with valid_out=1 for one cycle.
- Async reset mid-ACTIVE:
  - Stimulus: assert reset_L=0 between clock edges while data_out=8'h5A.
  - Response: data_out=00, valid_out=0, active=0 before the next edge.
  - Stimulus continued: after release, BC x4, 42.
  - Response: 42 delivered.
- BC_COUNT=1 build:
  - Stimulus: single BC, then 99.
  - Response: active on the BC-match edge; 8'h99 strobed 8 cycles later.
